// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, drives a variable-latency imem port, handles
// redirects, hazard stalls (one-entry hold buffer) and HLT. FETCH_PERF_EN adds a wait counter.
module fetch_sequencer (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instr_out,
    output logic        instr_valid,
    output logic [15:0] pc_out,
    output logic [15:0] pc_plus_two,
    output logic        flush,
    output logic        halted,
    output logic [15:0] fetch_wait_cycles
);

    typedef enum logic [1:0] {StFetch, StDrain, StHalt} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] target_q, target_d;
    logic [15:0] hold_data_q, hold_data_d;
    logic [15:0] hold_pc_q, hold_pc_d;
    logic        hold_v_q, hold_v_d;
    logic        outstanding_q, outstanding_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic        instr_valid_q, instr_valid_d;
    logic        flush_q, flush_d;
    logic        resp;
    logic        resp_hlt;
    logic        hold_hlt;

    assign resp     = imem_valid & imem_req;
    assign resp_hlt = imem_data[15:12] == 4'hF;
    assign hold_hlt = hold_data_q[15:12] == 4'hF;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: begin
                if (redirect) begin
                    // A live request cannot be withdrawn, so its answer must be drained.
                    if (imem_req & ~imem_valid) begin
                        state_d = StDrain;
                    end
                end else if (resp) begin
                    if (~stall & resp_hlt) begin
                        state_d = StHalt;
                    end
                end else if (hold_v_q & ~stall & hold_hlt) begin
                    state_d = StHalt;
                end
            end
            StDrain: begin
                if (resp) begin
                    state_d = StFetch;
                end
            end
            StHalt: begin
                if (redirect) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    // FSM: outputs
    always_comb begin
        imem_req = ~rst & (((state_q == StFetch) & ~hold_v_q & (~stall | outstanding_q)) |
                           (state_q == StDrain));
        halted   = state_q == StHalt;
    end

    assign imem_addr   = pc_q;
    assign instr_out   = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc_out      = pc_out_q;
    assign pc_plus_two = pc_out_q + 16'd2;
    assign flush       = flush_q;

    always_comb begin
        pc_d          = pc_q;
        target_d      = target_q;
        hold_data_d   = hold_data_q;
        hold_pc_d     = hold_pc_q;
        hold_v_d      = hold_v_q;
        instr_d       = instr_q;
        pc_out_d      = pc_out_q;
        instr_valid_d = instr_valid_q;
        flush_d       = redirect;
        outstanding_d = imem_req & ~imem_valid;
        case (state_q)
            StFetch: begin
                if (redirect) begin
                    instr_valid_d = 1'b0;
                    hold_v_d      = 1'b0;
                    if (imem_req & ~imem_valid) begin
                        target_d = redirect_pc;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (resp) begin
                    pc_d = pc_q + 16'd2;
                    if (stall) begin
                        hold_data_d = imem_data;
                        hold_pc_d   = pc_q;
                        hold_v_d    = 1'b1;
                    end else begin
                        instr_d       = imem_data;
                        pc_out_d      = pc_q;
                        instr_valid_d = 1'b1;
                    end
                end else if (~stall) begin
                    if (hold_v_q) begin
                        instr_d       = hold_data_q;
                        pc_out_d      = hold_pc_q;
                        instr_valid_d = 1'b1;
                        hold_v_d      = 1'b0;
                    end else begin
                        instr_valid_d = 1'b0;
                    end
                end
            end
            StDrain: begin
                if (redirect) begin
                    target_d = redirect_pc;
                end
                if (resp) begin
                    pc_d = redirect ? redirect_pc : target_q;
                end
            end
            StHalt: begin
                if (redirect) begin
                    pc_d          = redirect_pc;
                    instr_valid_d = 1'b0;
                end else if (~stall) begin
                    instr_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= 16'h0000;
            target_q      <= 16'h0000;
            hold_data_q   <= 16'h0000;
            hold_pc_q     <= 16'h0000;
            hold_v_q      <= 1'b0;
            outstanding_q <= 1'b0;
            instr_q       <= 16'h0000;
            pc_out_q      <= 16'h0000;
            instr_valid_q <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            target_q      <= target_d;
            hold_data_q   <= hold_data_d;
            hold_pc_q     <= hold_pc_d;
            hold_v_q      <= hold_v_d;
            outstanding_q <= outstanding_d;
            instr_q       <= instr_d;
            pc_out_q      <= pc_out_d;
            instr_valid_q <= instr_valid_d;
            flush_q       <= flush_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (imem_req & ~imem_valid & (wait_cnt_q != 16'hFFFF)) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= 16'h0000;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign fetch_wait_cycles = wait_cnt_q;
`else
    assign fetch_wait_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic against a behavioural
// model with a queue-based hold buffer and a latency-randomised memory.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic [15:0] pc_out;
    logic [15:0] pc_plus_two;
    logic        flush;
    logic        halted;
    logic [15:0] fetch_wait_cycles;

    fetch_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_valid       (imem_valid),
        .imem_data        (imem_data),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .instr_out        (instr_out),
        .instr_valid      (instr_valid),
        .pc_out           (pc_out),
        .pc_plus_two      (pc_plus_two),
        .flush            (flush),
        .halted           (halted),
        .fetch_wait_cycles(fetch_wait_cycles)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam int ModeFetch = 0;
    localparam int ModeDrain = 1;
    localparam int ModeHalt  = 2;

    int          m_mode;
    logic [15:0] m_pc, m_target, m_instr, m_ipc, m_wait;
    logic        m_iv, m_flush, m_busy;
    logic [31:0] m_hold[$];

    int          mem_left;
    int unsigned lat_lo, lat_hi;
    logic        hlt_en;
    logic [15:0] hlt_addr;

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_fail++;
        $error("FAIL timeout %s: condition not reached, required within budget", tag);
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (hlt_en && a == hlt_addr) return 16'hF000;
        return 16'h1000 + {1'b0, a[15:1]};
    endfunction

    function automatic logic model_req(input logic s);
        return (m_mode == ModeFetch && m_hold.size() == 0 && (!s || m_busy)) ||
               m_mode == ModeDrain;
    endfunction

    task automatic model_reset();
        m_mode   = ModeFetch;
        m_pc     = 16'h0000;
        m_target = 16'h0000;
        m_instr  = 16'h0000;
        m_ipc    = 16'h0000;
        m_iv     = 1'b0;
        m_flush  = 1'b0;
        m_busy   = 1'b0;
        m_wait   = 16'h0000;
        m_hold.delete();
        mem_left = -1;
    endtask

    task automatic deliver(input logic [15:0] a, input logic [15:0] d);
        m_instr = d;
        m_ipc   = a;
        m_iv    = 1'b1;
        if (d[15:12] == 4'hF) m_mode = ModeHalt;
    endtask

    task automatic model_update(input logic s, input logic r, input logic [15:0] rpc,
                                input logic req, input logic v, input logic [15:0] d);
        logic        resp;
        logic [31:0] h;
        resp    = v && req;
        m_flush = r;
        m_busy  = req && !v;
        case (m_mode)
            ModeFetch: begin
                if (r) begin
                    m_iv = 1'b0;
                    m_hold.delete();
                    if (req && !v) begin
                        m_target = rpc;
                        m_mode   = ModeDrain;
                    end else begin
                        m_pc = rpc;
                    end
                end else if (resp && !s) begin
                    deliver(m_pc, d);
                    m_pc = m_pc + 16'd2;
                end else if (resp) begin
                    m_hold.push_back({m_pc, d});
                    m_pc = m_pc + 16'd2;
                end else if (!s && m_hold.size() > 0) begin
                    h = m_hold.pop_front();
                    deliver(h[31:16], h[15:0]);
                end else if (!s) begin
                    m_iv = 1'b0;
                end
            end
            ModeDrain: begin
                if (r) m_target = rpc;
                if (v) begin
                    m_pc   = m_target;
                    m_mode = ModeFetch;
                end
            end
            default: begin
                if (r) begin
                    m_pc   = rpc;
                    m_iv   = 1'b0;
                    m_mode = ModeFetch;
                end else if (!s) begin
                    m_iv = 1'b0;
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        check16("instr_out", instr_out, m_instr);
        check1("instr_valid", instr_valid, m_iv);
        check16("pc_out", pc_out, m_ipc);
        check16("pc_plus_two", pc_plus_two, m_ipc + 16'd2);
        check1("flush", flush, m_flush);
        check1("halted", halted, m_mode == ModeHalt);
`ifdef FETCH_PERF_EN
        check16("fetch_wait_cycles", fetch_wait_cycles, m_wait);
`else
        check16("fetch_wait_cycles", fetch_wait_cycles, 16'h0000);
`endif
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step(input logic s, input logic r, input logic [15:0] rpc);
        logic        exp_req;
        logic        v;
        logic [15:0] d;
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        #1;
        exp_req = model_req(s);
        check1("imem_req", imem_req, exp_req);
        if (exp_req) check16("imem_addr", imem_addr, m_pc);
        v = 1'b0;
        d = 16'($urandom);
        if (imem_req) begin
            if (mem_left < 0) mem_left = int'($urandom_range(lat_hi, lat_lo));
            if (mem_left == 0) begin
                v        = 1'b1;
                d        = mem_word(imem_addr);
                mem_left = -1;
            end else begin
                mem_left--;
            end
        end else begin
            mem_left = -1;
        end
        imem_valid = v;
        imem_data  = d;
        if (exp_req && !v && m_wait != 16'hFFFF) m_wait = m_wait + 16'd1;
        @(posedge clk);
        model_update(s, r, rpc, exp_req, v, d);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        stall      = 1'b0;
        redirect   = 1'b0;
        imem_valid = 1'b0;
        imem_data  = 16'h0000;
        model_reset();
        #1;
        check1("rst_imem_req", imem_req, 1'b0);
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int k;
        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        imem_valid  = 1'b0;
        imem_data   = 16'h0000;
        hlt_en      = 1'b0;
        hlt_addr    = 16'h0000;
        lat_lo      = 0;
        lat_hi      = 0;
        model_reset();
        @(negedge clk);

        // Zero-wait sequence
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 16'h0);
            check16("zw_pc_out", pc_out, 16'(2 * i));
            check16("zw_instr", instr_out, 16'(16'h1000 + i));
            check1("zw_valid", instr_valid, 1'b1);
        end

        // Stall with hold
        do_reset();
        lat_lo = 2;
        lat_hi = 2;
        k = 0;
        while (!(m_pc == 16'h0004 && m_busy && mem_left == 0) && k < 40) begin
            step(1'b0, 1'b0, 16'h0);
            k++;
        end
        if (k >= 40) timeout("hold_setup");
        step(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 16'h0);
            check1("hold_req_low", imem_req, 1'b0);
        end
        step(1'b0, 1'b0, 16'h0);
        check16("hold_pc_out", pc_out, 16'h0004);
        check1("hold_next_req", imem_req, 1'b1);
        check16("hold_next_addr", imem_addr, 16'h0006);

        // Redirect while outstanding
        k = 0;
        while (!(m_pc == 16'h0008 && m_busy && mem_left > 0 && m_mode == ModeFetch) &&
               k < 40) begin
            step(1'b0, 1'b0, 16'h0);
            k++;
        end
        if (k >= 40) timeout("drain_setup");
        step(1'b0, 1'b1, 16'h0040);
        check1("drain_flush", flush, 1'b1);
        check1("drain_valid", instr_valid, 1'b0);
        k = 0;
        while (m_mode != ModeFetch && k < 10) begin
            step(1'b0, 1'b0, 16'h0);
            k++;
        end
        if (k >= 10) timeout("drain_exit");
        check16("drain_next_addr", imem_addr, 16'h0040);

        // Same-cycle redirect and response
        lat_lo = 0;
        lat_hi = 0;
        step(1'b0, 1'b1, 16'h000C);
        k = 0;
        while (!(m_pc == 16'h0010 && m_mode == ModeFetch && m_hold.size() == 0) && k < 10) begin
            step(1'b0, 1'b0, 16'h0);
            k++;
        end
        if (k >= 10) timeout("same_setup");
        step(1'b0, 1'b1, 16'h0100);
        check1("same_valid", instr_valid, 1'b0);
        check1("same_flush", flush, 1'b1);
        check16("same_next_addr", imem_addr, 16'h0100);

        // Halt
        hlt_en   = 1'b1;
        hlt_addr = 16'h0020;
        step(1'b0, 1'b1, 16'h001C);
        k = 0;
        while (m_mode != ModeHalt && k < 20) begin
            step(1'b0, 1'b0, 16'h0);
            k++;
        end
        if (k >= 20) timeout("halt_entry");
        check1("halt_halted", halted, 1'b1);
        check16("halt_instr", instr_out, 16'hF000);
        check16("halt_pc_out", pc_out, 16'h0020);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 16'h0);
            check1("halt_req_low", imem_req, 1'b0);
        end
        step(1'b0, 1'b1, 16'h0030);
        check1("halt_exit", halted, 1'b0);
        check1("halt_resume_req", imem_req, 1'b1);
        check16("halt_resume_addr", imem_addr, 16'h0030);

        // Wait-cycle counter: five 4-cycle fetches, the fifth is HLT
        do_reset();
        lat_lo   = 3;
        lat_hi   = 3;
        hlt_addr = 16'h0008;
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 16'h0);
        check1("perf_halted", halted, 1'b1);
`ifdef FETCH_PERF_EN
        check16("perf_count", fetch_wait_cycles, 16'd15);
`else
        check16("perf_count", fetch_wait_cycles, 16'h0000);
`endif

        // Random traffic
        do_reset();
        lat_lo   = 0;
        lat_hi   = 3;
        hlt_addr = 16'h003A;
        for (int i = 0; i < 800; i++) begin
            logic        s;
            logic        r;
            logic [15:0] rpc;
            if (i == 400) do_reset();
            s   = ($urandom % 10) < 3;
            r   = ($urandom % 20) == 0;
            rpc = (($urandom % 8) == 0) ? 16'hFFFA : 16'(2 * $urandom_range(40, 0));
            step(s, r, rpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
